// File: rtl/serial_adder_frame_ctrl_if.sv
// Operand / result handshake bundle for serial_adder_frame_ctrl.
// The controller uses the slave view; the producer/consumer side uses master.
interface serial_adder_frame_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             op_valid;
    logic             op_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_carry;

    modport master (
        output op_valid, op_a, op_b, res_ready,
        input  op_ready, res_valid, res_data, res_carry
    );

    modport slave (
        input  op_valid, op_a, op_b, res_ready,
        output op_ready, res_valid, res_data, res_carry
    );
endinterface

// File: rtl/serial_adder_frame_ctrl.sv
// Operand serializer / result deserializer around an external 1-bit serial adder.
// Operands go out LSB-first on ser_a/ser_b, sum bits come back on ser_sum.
// Optional feature macro: SERIAL_ADDER_FRAME_CARRY_OUT_EN adds one zero-operand
// cycle whose sum bit is the final carry, reported on res_carry.
module serial_adder_frame_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    serial_adder_frame_ctrl_if.slave bus,
    output logic                    ser_clr,
    output logic                    ser_a,
    output logic                    ser_b,
    input  logic                    ser_sum
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
`ifdef SERIAL_ADDER_FRAME_CARRY_OUT_EN
    localparam int unsigned NBITS = WIDTH + 1;
`else
    localparam int unsigned NBITS = WIDTH;
`endif
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NBITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             op_ready_q;
    logic             res_valid_q;
    logic             ser_clr_q;
    logic             ser_a_q;
    logic             ser_b_q;

    // Next shift-register contents; the sum bit enters at the MSB.
    logic [WIDTH-1:0] a_shr;
    logic [WIDTH-1:0] b_shr;
    logic [WIDTH-1:0] res_shr;
    assign a_shr   = a_sr >> 1;
    assign b_shr   = b_sr >> 1;
    assign res_shr = WIDTH'({ser_sum, res_sr} >> 1);

`ifdef SERIAL_ADDER_FRAME_CARRY_OUT_EN
    logic res_carry_q;
    assign bus.res_carry = res_carry_q;
`else
    assign bus.res_carry = 1'b0;
`endif

    assign bus.op_ready  = op_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_sr;
    assign ser_clr       = ser_clr_q;
    assign ser_a         = ser_a_q;
    assign ser_b         = ser_b_q;

    // Frame FSM with datapath and registered state-decoded outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            a_sr        <= '0;
            b_sr        <= '0;
            res_sr      <= '0;
            op_ready_q  <= 1'b1;
            res_valid_q <= 1'b0;
            ser_clr_q   <= 1'b1;
            ser_a_q     <= 1'b0;
            ser_b_q     <= 1'b0;
`ifdef SERIAL_ADDER_FRAME_CARRY_OUT_EN
            res_carry_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.op_valid) begin
                        state      <= SHIFT;
                        a_sr       <= bus.op_a;
                        b_sr       <= bus.op_b;
                        cnt        <= '0;
                        op_ready_q <= 1'b0;
                        ser_clr_q  <= 1'b0;
                        ser_a_q    <= bus.op_a[0];
                        ser_b_q    <= bus.op_b[0];
`ifdef SERIAL_ADDER_FRAME_CARRY_OUT_EN
                        res_carry_q <= 1'b0;
`endif
                    end
                end
                SHIFT: begin
                    a_sr <= a_shr;
                    b_sr <= b_shr;
                    cnt  <= cnt + CNT_W'(1);
`ifdef SERIAL_ADDER_FRAME_CARRY_OUT_EN
                    // The extra cycle's sum bit is the adder's final carry.
                    if (cnt == LAST) begin
                        res_carry_q <= ser_sum;
                    end else begin
                        res_sr <= res_shr;
                    end
`else
                    res_sr <= res_shr;
`endif
                    if (cnt == LAST) begin
                        state       <= DONE;
                        res_valid_q <= 1'b1;
                        ser_a_q     <= 1'b0;
                        ser_b_q     <= 1'b0;
                    end else begin
                        ser_a_q <= a_shr[0];
                        ser_b_q <= b_shr[0];
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        state       <= IDLE;
                        res_valid_q <= 1'b0;
                        op_ready_q  <= 1'b1;
                        ser_clr_q   <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    res_valid_q <= 1'b0;
                    op_ready_q  <= 1'b1;
                    ser_clr_q   <= 1'b1;
                    ser_a_q     <= 1'b0;
                    ser_b_q     <= 1'b0;
                end
            endcase
        end
    end
endmodule
